// File: rtl/prog_clock_divider.sv
// -----------------------------------------------------------------------------
// prog_clock_divider
//
// Programmable clock divider. It produces a registered 50% duty square wave
// whose half-period is (active_div + 1) cycles of clk. The full output period
// is therefore 2*(active_div+1) cycles. A divide value of 0 gives divide-by-2.
//
// A new divide value is staged through a one-entry pending register. It is
// only promoted to the active value at a terminal edge, so the output never
// glitches and never produces a shortened half-period.
//
// Parameters
//   WIDTH        width of the half-period counter and of the divide value
//   DEFAULT_DIV  divide value loaded at reset (must fit in WIDTH bits)
//
// Ports
//   clk      in   single clock; all state changes on its rising edge
//   rst_n    in   synchronous active-low reset; overrides clr, load and en
//   en       in   count enable; while low, cnt and clk_out hold
//   clr      in   synchronous phase clear: cnt=0 and clk_out=0; the
//                 pending and active divide values are left untouched
//   load     in   one-cycle strobe that captures div_in as the pending value
//   div_in   in   requested divide value D; half-period = D+1 clk cycles
//   clk_out  out  divided square wave, registered
//   tick     out  one-cycle pulse in the first cycle clk_out shows a new level
//   rise     out  tick qualified by clk_out == 1
//   fall     out  tick qualified by clk_out == 0
//   cnt      out  current half-period counter value
// -----------------------------------------------------------------------------
module prog_clock_divider #(
  parameter int unsigned           WIDTH       = 23,
  parameter logic [WIDTH-1:0]      DEFAULT_DIV = 4999999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             rise,
  output logic             fall,
  output logic [WIDTH-1:0] cnt
);

  // ---------------------------------------------------------------------------
  // Divide-value registers
  //   active_div  governs the half-period that is currently running
  //   pend_div    last value captured by load, waiting for a terminal edge
  //   pend_valid  pend_div holds a value that has not been applied yet
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;

  // ---------------------------------------------------------------------------
  // Terminal detection
  // A terminal edge ends the current half-period. clr wins over counting, so a
  // cycle with clr set is never a terminal even if cnt happens to match.
  // cnt never exceeds active_div: it is only incremented while below it, and
  // active_div only changes on a terminal edge, where cnt returns to 0.
  // ---------------------------------------------------------------------------
  logic terminal;
  logic at_limit;

  always_comb begin
    at_limit = (cnt == active_div);
    terminal = en && !clr && at_limit;
  end

  // ---------------------------------------------------------------------------
  // Next-value logic for the counter and the square wave
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] cnt_nxt;
  logic             clk_out_nxt;

  always_comb begin
    cnt_nxt     = cnt;
    clk_out_nxt = clk_out;
    if (clr) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
    end else if (en) begin
      if (at_limit) begin
        cnt_nxt     = '0;
        clk_out_nxt = ~clk_out;
      end else begin
        cnt_nxt     = cnt + WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-value logic for the divide registers
  // The terminal consumes the pending value as it stood before this edge.
  // A load on the same edge is applied afterwards, so it overwrites pend_div
  // and re-arms pend_valid for the following terminal rather than being
  // consumed immediately. clr has no effect here.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] active_div_nxt;
  logic [WIDTH-1:0] pend_div_nxt;
  logic             pend_valid_nxt;

  always_comb begin
    active_div_nxt = active_div;
    pend_div_nxt   = pend_div;
    pend_valid_nxt = pend_valid;
    if (terminal && pend_valid) begin
      active_div_nxt = pend_div;
      pend_valid_nxt = 1'b0;
    end
    if (load) begin
      pend_div_nxt   = div_in;
      pend_valid_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe next values
  // The strobes are registered copies of the terminal condition. They line up
  // with the cycle in which clk_out first shows its new level. The direction
  // is taken from the level being left: leaving 0 means the new level is 1.
  // ---------------------------------------------------------------------------
  logic tick_nxt;
  logic rise_nxt;
  logic fall_nxt;

  always_comb begin
    tick_nxt = terminal;
    rise_nxt = terminal && !clk_out;
    fall_nxt = terminal &&  clk_out;
  end

  // ---------------------------------------------------------------------------
  // Counter and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= clk_out_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      tick <= tick_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Divide-value registers
  // Reset drops any pending load and restores the default divide value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_div <= DEFAULT_DIV;
      pend_div   <= DEFAULT_DIV;
      pend_valid <= 1'b0;
    end else begin
      active_div <= active_div_nxt;
      pend_div   <= pend_div_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clock_divider
//
// Self-checking bench for prog_clock_divider with WIDTH=4, DEFAULT_DIV=3.
// A table of expected output records covers free-running operation. Short
// hand-written sequences cover the reload, enable, clear and reset corners.
// Half-period lengths are checked against an expected queue.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_prog_clock_divider;

  localparam int W = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic         load;
  logic [W-1:0] div_in;
  logic         clk_out;
  logic         tick;
  logic         rise;
  logic         fall;
  logic [W-1:0] cnt;

  always #5 clk = ~clk;

  prog_clock_divider #(
    .WIDTH      (W),
    .DEFAULT_DIV(4'd3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .load   (load),
    .div_in (div_in),
    .clk_out(clk_out),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .cnt    (cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string name, input int e_cnt, input int e_clk,
                               input int e_tick, input int e_rise, input int e_fall);
    check({name, ".cnt"},     int'(cnt),     e_cnt);
    check({name, ".clk_out"}, int'(clk_out), e_clk);
    check({name, ".tick"},    int'(tick),    e_tick);
    check({name, ".rise"},    int'(rise),    e_rise);
    check({name, ".fall"},    int'(fall),    e_fall);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    load   = 1'b0;
    div_in = '0;
    cycles(2);
    rst_n  = 1'b1;
  endtask

  task automatic do_load(input logic [W-1:0] value);
    load   = 1'b1;
    div_in = value;
    cycle();
    load   = 1'b0;
    div_in = '0;
  endtask

  // Runs cycles until tick is seen (bounded) and compares the number of
  // elapsed cycles with the next entry of the expected queue.
  task automatic check_half(input string name);
    int n;
    logic [7:0] e;
    e = exp_q.pop_front();
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick && n < 40);
    check(name, n, int'(e));
  endtask

  // ---------------------------------------------------------------------------
  // Free-running vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         en;
    logic [W-1:0] cnt;
    logic         clk_out;
    logic         tick;
    logic         rise;
    logic         fall;
  } vec_t;

  vec_t vecs[20];

  task automatic fill_vectors();
    //            en   cnt  clk  tick rise fall
    vecs[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    load   = 1'b0;
    div_in = '0;
    fill_vectors();
    @(negedge clk);

    // Reset state and free-running divide by 8
    do_reset();
    check_outputs("reset", 0, 0, 0, 0, 0);
    check("reset.active_div", int'(dut.active_div), 3);
    check("reset.pend_valid", int'(dut.pend_valid), 0);
    for (int i = 0; i < 20; i++) begin
      en = vecs[i].en;
      cycle();
      check_outputs($sformatf("run[%0d]", i), int'(vecs[i].cnt), int'(vecs[i].clk_out),
                    int'(vecs[i].tick), int'(vecs[i].rise), int'(vecs[i].fall));
    end

    // Load 1 at cnt=1: the running half-period keeps 4 cycles, then 2
    do_reset();
    en = 1'b1;
    cycle();
    check("ld1.cnt", int'(cnt), 1);
    do_load(4'd1);
    check("ld1.pend_valid", int'(dut.pend_valid), 1);
    check("ld1.active_old", int'(dut.active_div), 3);
    exp_q.push_back(8'd2);              // remainder of the first 4-cycle half
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd2);
    check_half("ld1.half0");
    check("ld1.active_new", int'(dut.active_div), 1);
    check("ld1.pend_clear", int'(dut.pend_valid), 0);
    check("ld1.rise", int'(rise), 1);
    check_half("ld1.half1");
    check("ld1.fall", int'(fall), 1);
    check_half("ld1.half2");

    // Load 0 exactly at the terminal: one more 4-cycle half, then divide-by-2
    do_reset();
    en = 1'b1;
    cycles(3);
    check("ld0.cnt", int'(cnt), 3);
    do_load(4'd0);
    check("ld0.tick", int'(tick), 1);
    check("ld0.active_keep", int'(dut.active_div), 3);
    check("ld0.pend_valid", int'(dut.pend_valid), 1);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd1);
    check_half("ld0.half_old");
    check("ld0.active_new", int'(dut.active_div), 0);
    check_half("ld0.half_d2a");
    check("ld0.clk_a", int'(clk_out), 1);
    check_half("ld0.half_d2b");
    check("ld0.clk_b", int'(clk_out), 0);

    // en=0 for 5 cycles at cnt=2, clk_out=1
    do_reset();
    en = 1'b1;
    cycles(6);
    check("hold.cnt_pre", int'(cnt), 2);
    check("hold.clk_pre", int'(clk_out), 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_outputs($sformatf("hold[%0d]", i), 2, 1, 0, 0, 0);
    end
    en = 1'b1;
    exp_q.push_back(8'd2);
    check_half("hold.resume");
    check("hold.clk_post", int'(clk_out), 0);
    check("hold.fall", int'(fall), 1);

    // clr at cnt=2, clk_out=1 with 5 pending; clr and load also coincide
    do_reset();
    en = 1'b1;
    cycles(5);
    check("clr.cnt_pre", int'(cnt), 1);
    do_load(4'd5);
    check("clr.clk_pre", int'(clk_out), 1);
    check("clr.cnt_pre2", int'(cnt), 2);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check_outputs("clr", 0, 0, 0, 0, 0);
    check("clr.pend_valid", int'(dut.pend_valid), 1);
    check("clr.active_keep", int'(dut.active_div), 3);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd6);
    check_half("clr.half_old");
    check("clr.active_new", int'(dut.active_div), 5);
    check_half("clr.half6a");
    check_half("clr.half6b");
    // clr and load on the same edge: both act, pending is not applied by clr
    clr    = 1'b1;
    load   = 1'b1;
    div_in = 4'd2;
    cycle();
    clr    = 1'b0;
    load   = 1'b0;
    check("clrld.cnt", int'(cnt), 0);
    check("clrld.pend_div", int'(dut.pend_div), 2);
    check("clrld.active", int'(dut.active_div), 5);
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd3);
    check_half("clrld.half_old");
    check_half("clrld.half_new");

    // Reset mid half-period discards the pending load
    do_reset();
    en = 1'b1;
    cycle();
    do_load(4'd7);
    check("rst.pend_valid_pre", int'(dut.pend_valid), 1);
    check("rst.cnt_pre", int'(cnt), 2);
    rst_n = 1'b0;
    cycle();
    check_outputs("rst", 0, 0, 0, 0, 0);
    check("rst.active_div", int'(dut.active_div), 3);
    check("rst.pend_valid", int'(dut.pend_valid), 0);
    rst_n = 1'b1;
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd4);
    check_half("rst.half_a");
    check_half("rst.half_b");
    check("rst.active_post", int'(dut.active_div), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
